// File: rtl/alarm_controller.sv
// Alarm controller: stores one BCD alarm time and rings when the Digital_Clock time reaches it.
// Snooze support (SNOOZE state, snooze timer and snooze counter) is built only when ALARM_SNOOZE_EN is defined.
module alarm_controller #(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 600,
    parameter int MAX_SNOOZE       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic [7:0] hh,
    input  logic [7:0] mm,
    input  logic [7:0] ss,
    input  logic       pm,
    input  logic       set_alarm,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic       set_pm,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic       armed,
    output logic       snoozing,
    output logic [7:0] alarm_hh,
    output logic [7:0] alarm_mm,
    output logic       alarm_pm,
    output logic       bad_set,
    output logic [1:0] fsm_state
);
    // Handshakes: set_alarm, snooze and stop are single-cycle pulses sampled on
    // the rising clk edge; there is no back-pressure and no ready signal.
    localparam int RING_W = $clog2(RING_TIMEOUT_SEC + 1);
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT_SEC - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int TMR_W  = $clog2(SNOOZE_SEC + 1);
    localparam int SCNT_W = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(SNOOZE_SEC);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;

    logic [TMR_W-1:0]  tmr, tmr_n;
    logic [SCNT_W-1:0] snooze_cnt, snooze_cnt_n;
`else
    typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;

    logic unused_snooze;
    assign unused_snooze = snooze ^ SNOOZE_SEC[0] ^ MAX_SNOOZE[0];
`endif

    state_t            state, state_n;
    logic [RING_W-1:0] ring_cnt, ring_cnt_n;
    logic              match, match_q, hit, set_ok;

    assign set_ok = (set_hh[7:4] <= 4'd9) && (set_hh[3:0] <= 4'd9) &&
                    (set_mm[7:4] <= 4'd9) && (set_mm[3:0] <= 4'd9) &&
                    (set_hh >= 8'h01) && (set_hh <= 8'h12) && (set_mm <= 8'h59);

    // Only the first cycle of a matching second counts, so a held time rings once.
    assign match = (hh == alarm_hh) && (mm == alarm_mm) && (pm == alarm_pm) && (ss == 8'h00);
    assign hit   = match & ~match_q;

    assign fsm_state = state;

    always_comb begin
        state_n    = state;
        ring_cnt_n = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        tmr_n        = tmr;
        snooze_cnt_n = snooze_cnt;
`endif
        if (!arm) begin
            state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_n = '0;
`endif
        end else begin
            case (state)
                IDLE: state_n = ARMED;
                ARMED: begin
                    if (hit) begin
                        state_n    = RINGING;
                        ring_cnt_n = '0;
`ifdef ALARM_SNOOZE_EN
                        snooze_cnt_n = '0;
`endif
                    end
                end
                RINGING: begin
                    if (stop) begin
                        state_n = ARMED;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        // A refused snooze still swallows a coincident tick.
                        if (snooze_cnt < SCNT_MAX) begin
                            state_n      = SNOOZE;
                            tmr_n        = TMR_LOAD;
                            snooze_cnt_n = snooze_cnt + 1'b1;
                        end
`endif
                    end else if (sec_tick) begin
                        ring_cnt_n = ring_cnt + 1'b1;
                        if (ring_cnt == RING_LAST) state_n = ARMED;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (stop) begin
                        state_n = ARMED;
                    end else if (snooze) begin
                        state_n = SNOOZE;
                    end else if (sec_tick) begin
                        if (tmr <= TMR_W'(1)) begin
                            state_n    = RINGING;
                            tmr_n      = '0;
                            ring_cnt_n = '0;
                        end else begin
                            tmr_n = tmr - 1'b1;
                        end
                    end
                end
`endif
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ring_cnt <= '0;
            match_q  <= 1'b0;
            ring     <= 1'b0;
            armed    <= 1'b0;
            snoozing <= 1'b0;
            bad_set  <= 1'b0;
            alarm_hh <= 8'h12;
            alarm_mm <= 8'h00;
            alarm_pm <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            tmr        <= '0;
            snooze_cnt <= '0;
`endif
        end else begin
            state    <= state_n;
            ring_cnt <= ring_cnt_n;
            match_q  <= match;
            ring     <= (state_n == RINGING);
            armed    <= (state_n != IDLE);
            bad_set  <= set_alarm && !set_ok;
`ifdef ALARM_SNOOZE_EN
            tmr        <= tmr_n;
            snooze_cnt <= snooze_cnt_n;
            snoozing   <= (state_n == SNOOZE);
`else
            snoozing   <= 1'b0;
`endif
            if (set_alarm && set_ok) begin
                alarm_hh <= set_hh;
                alarm_mm <= set_mm;
                alarm_pm <= set_pm;
            end
        end
    end
endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed scenarios plus randomized traffic against a
// seconds-of-day reference model; snooze scenarios follow ALARM_SNOOZE_EN.
module tb_alarm_controller;
    localparam int RT = 4;
    localparam int SS = 3;
    localparam int MS = 1;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3;
    localparam int T0730 = 7 * 3600 + 30 * 60;

    logic       clk = 1'b0, reset = 1'b0, sec_tick = 1'b0, pm = 1'b0;
    logic       set_alarm = 1'b0, set_pm = 1'b0, arm = 1'b0, snooze = 1'b0, stop = 1'b0;
    logic [7:0] hh = 8'h01, mm = 8'h00, ss = 8'h00, set_hh = 8'h00, set_mm = 8'h00;
    logic       ring, armed, snoozing, alarm_pm, bad_set;
    logic [7:0] alarm_hh, alarm_mm;
    logic [1:0] fsm_state;

    int total = 0;
    int bad = 0;

    // reference model: mode, seconds rung, snooze seconds left, snoozes used, alarm as BCD
    int         m_mode, m_rung, m_left, m_used;
    bit         m_prev, m_bad;
    logic [7:0] m_ah, m_am;
    logic       m_ap;
    logic [20:0] exp_q[$];

    alarm_controller #(.SNOOZE_SEC(SS), .RING_TIMEOUT_SEC(RT), .MAX_SNOOZE(MS)) dut (
        .clk(clk), .reset(reset), .sec_tick(sec_tick), .hh(hh), .mm(mm), .ss(ss), .pm(pm),
        .set_alarm(set_alarm), .set_hh(set_hh), .set_mm(set_mm), .set_pm(set_pm),
        .arm(arm), .snooze(snooze), .stop(stop), .ring(ring), .armed(armed),
        .snoozing(snoozing), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_pm(alarm_pm),
        .bad_set(bad_set), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int dec(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int tod(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
        return ((dec(h) % 12) + (p ? 12 : 0)) * 3600 + dec(m) * 60 + dec(s);
    endfunction

    function automatic bit set_valid(input logic [7:0] h, input logic [7:0] m);
        if (h[7:4] > 4'd9 || h[3:0] > 4'd9 || m[7:4] > 4'd9 || m[3:0] > 4'd9) return 1'b0;
        return (dec(h) >= 1) && (dec(h) <= 12) && (dec(m) <= 59);
    endfunction

    function automatic logic [20:0] exp_vec();
        return {m_mode == M_RING, m_mode != M_IDLE, m_mode == M_SNZ, m_bad, m_ah, m_am, m_ap};
    endfunction

    function automatic logic [20:0] obs_vec();
        return {ring, armed, snoozing, bad_set, alarm_hh, alarm_mm, alarm_pm};
    endfunction

    task automatic drive_tod(input int t);
        int hr24;
        hr24 = t / 3600;
        pm   = (hr24 >= 12);
        hh   = bcd((hr24 % 12 == 0) ? 12 : hr24 % 12);
        mm   = bcd((t / 60) % 60);
        ss   = bcd(t % 60);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rung = 0; m_left = 0; m_used = 0;
        m_prev = 1'b0; m_bad = 1'b0;
        m_ah = 8'h12; m_am = 8'h00; m_ap = 1'b0;
    endtask

    task automatic model_step();
        bit now_m, hit, snz, ok;
        now_m  = (tod(hh, mm, ss, pm) == tod(m_ah, m_am, 8'h00, m_ap));
        hit    = now_m && !m_prev;
        m_prev = now_m;
        ok     = set_valid(set_hh, set_mm);
        m_bad  = set_alarm && !ok;
        if (set_alarm && ok) begin m_ah = set_hh; m_am = set_mm; m_ap = set_pm; end
        snz = SNZ_EN && snooze;
        if (!arm) begin
            m_mode = M_IDLE; m_used = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ARMED;
        end else if (m_mode == M_ARMED) begin
            if (hit) begin m_mode = M_RING; m_rung = 0; m_used = 0; end
        end else if (stop) begin
            m_mode = M_ARMED;
        end else if (snz) begin
            if (m_mode == M_RING && m_used < MS) begin m_mode = M_SNZ; m_left = SS; m_used++; end
        end else if (sec_tick) begin
            if (m_mode == M_RING) begin
                m_rung++;
                if (m_rung == RT) m_mode = M_ARMED;
            end else begin
                m_left--;
                if (m_left == 0) begin m_mode = M_RING; m_rung = 0; end
            end
        end
    endtask

    // one clock: model follows the same sampled inputs, pulses drop afterwards
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0; sec_tick = 1'b0;
    endtask

    task automatic ring_up();
        drive_tod(T0730 - 1);
        step();
        drive_tod(T0730);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; arm = 1'b0;
        drive_tod(3600);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        total++;
        if ({ring, armed, snoozing, bad_set} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {ring, armed, snoozing, bad_set});
        end
        total++;
        if ({alarm_hh, alarm_mm, alarm_pm} !== {8'h12, 8'h00, 1'b0}) begin
            bad++; $display("FAIL reset_alarm: got %h:%h pm=%b want 12:00 pm=0", alarm_hh, alarm_mm, alarm_pm);
        end
        reset = 1'b1;
    endtask

    task automatic test_set_and_ring();
        drive_tod(7 * 3600);
        set_alarm = 1'b1; set_hh = 8'h07; set_mm = 8'h30; set_pm = 1'b0; arm = 1'b1;
        step();
        total++;
        if ({alarm_hh, alarm_mm, alarm_pm, armed, bad_set} !== {8'h07, 8'h30, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL set_load: got %h:%h pm=%b armed=%b bad=%b want 07:30 pm=0 armed=1 bad=0",
                            alarm_hh, alarm_mm, alarm_pm, armed, bad_set);
        end
        drive_tod(T0730 - 1);
        step();
        total++;
        if (ring !== 1'b0) begin bad++; $display("FAIL ring_before: got %b want 0", ring); end
        drive_tod(T0730);
        step();
        total++;
        if (ring !== 1'b1) begin bad++; $display("FAIL ring_on_hit: got %b want 1", ring); end
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL ring_model: got %h want %h", obs_vec(), exp_vec()); end
        stop = 1'b1;
        step();
        total++;
        if ({ring, armed} !== 2'b01) begin bad++; $display("FAIL stop: got ring=%b armed=%b want 0 1", ring, armed); end
    endtask

    task automatic test_bad_set();
        logic [7:0] hh_tab [3];
        logic [7:0] mm_tab [3];
        hh_tab[0] = 8'h13; mm_tab[0] = 8'h45;
        hh_tab[1] = 8'h07; mm_tab[1] = 8'h5A;
        hh_tab[2] = 8'h00; mm_tab[2] = 8'h10;
        for (int i = 0; i < 3; i++) begin
            set_alarm = 1'b1; set_hh = hh_tab[i]; set_mm = mm_tab[i]; set_pm = 1'b1;
            step();
            total++;
            if ({bad_set, alarm_hh, alarm_mm, alarm_pm} !== {1'b1, 8'h07, 8'h30, 1'b0}) begin
                bad++; $display("FAIL bad_set_%0d: got bad=%b %h:%h pm=%b want bad=1 07:30 pm=0",
                                i, bad_set, alarm_hh, alarm_mm, alarm_pm);
            end
            step();
            total++;
            if (bad_set !== 1'b0) begin bad++; $display("FAIL bad_set_pulse_%0d: got %b want 0", i, bad_set); end
        end
    endtask

    task automatic test_timeout();
        ring_up();
        for (int i = 1; i <= RT; i++) begin
            sec_tick = 1'b1;
            step();
            total++;
            if (ring !== (i < RT)) begin bad++; $display("FAIL timeout_tick_%0d: got ring=%b want %b", i, ring, i < RT); end
            step();
        end
        total++;
        if (armed !== 1'b1) begin bad++; $display("FAIL timeout_armed: got %b want 1", armed); end
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1'b1;
            step();
            total++;
            if (ring !== 1'b0) begin bad++; $display("FAIL no_rering_%0d: got %b want 0", i, ring); end
        end
    endtask

    task automatic test_snooze();
        ring_up();
        snooze = 1'b1;
        step();
`ifdef ALARM_SNOOZE_EN
        total++;
        if ({snoozing, ring} !== 2'b10) begin bad++; $display("FAIL snooze_enter: got snz=%b ring=%b want 1 0", snoozing, ring); end
        for (int i = 1; i <= SS; i++) begin
            sec_tick = 1'b1;
            step();
            total++;
            if (ring !== (i == SS)) begin bad++; $display("FAIL snooze_tick_%0d: got ring=%b want %b", i, ring, i == SS); end
        end
        snooze = 1'b1;
        step();
        total++;
        if ({snoozing, ring} !== 2'b01) begin bad++; $display("FAIL snooze_limit: got snz=%b ring=%b want 0 1", snoozing, ring); end
`else
        total++;
        if ({snoozing, ring} !== 2'b01) begin bad++; $display("FAIL snooze_ignored: got snz=%b ring=%b want 0 1", snoozing, ring); end
`endif
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL snooze_model: got %h want %h", obs_vec(), exp_vec()); end
        stop = 1'b1;
        step();
    endtask

    task automatic test_stop_snooze_same();
        ring_up();
        stop = 1'b1; snooze = 1'b1; sec_tick = 1'b1;
        step();
        total++;
        if ({ring, armed, snoozing} !== 3'b010) begin
            bad++; $display("FAIL stop_vs_snooze: got ring=%b armed=%b snz=%b want 0 1 0", ring, armed, snoozing);
        end
    endtask

    task automatic test_arm_off();
        ring_up();
        arm = 1'b0;
        step();
        total++;
        if ({ring, armed} !== 2'b00) begin bad++; $display("FAIL arm_off: got ring=%b armed=%b want 0 0", ring, armed); end
        arm = 1'b1;
        step();
        total++;
        if (armed !== 1'b1) begin bad++; $display("FAIL rearm: got %b want 1", armed); end
    endtask

    task automatic test_reset_mid_ring();
        ring_up();
        reset = 1'b0;
        #1;
        total++;
        if ({ring, alarm_hh, alarm_mm, alarm_pm} !== {1'b0, 8'h12, 8'h00, 1'b0}) begin
            bad++; $display("FAIL reset_mid_ring: got ring=%b %h:%h pm=%b want 0 12:00 pm=0", ring, alarm_hh, alarm_mm, alarm_pm);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [20:0] ev;
        for (int i = 0; i < 600; i++) begin
            int at;
            at = tod(m_ah, m_am, 8'h00, m_ap);
            case ($urandom_range(0, 3))
                0, 2:    drive_tod(at);
                1:       drive_tod((at + 86399) % 86400);
                default: drive_tod(int'($urandom_range(0, 86399)));
            endcase
            arm      = ($urandom_range(0, 30) != 0);
            sec_tick = $urandom_range(0, 1) != 0;
            stop     = ($urandom_range(0, 15) == 0);
            snooze   = ($urandom_range(0, 5) == 0);
            set_alarm = ($urandom_range(0, 40) == 0);
            set_hh   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : bcd(int'($urandom_range(1, 12)));
            set_mm   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : bcd(int'($urandom_range(0, 59)));
            set_pm   = $urandom_range(0, 1) != 0;
            step();
            exp_q.push_back(exp_vec());
            ev = exp_q.pop_front();
            total++;
            if (obs_vec() !== ev) begin bad++; $display("FAIL random_%0d: got %h want %h", i, obs_vec(), ev); end
        end
    endtask

    initial begin
        test_reset();
        test_set_and_ring();
        test_bad_set();
        test_timeout();
        test_snooze();
        test_stop_snooze_same();
        test_arm_off();
        test_reset_mid_ring();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
